// File: rtl/pwm_dac_out.sv
// PWM DAC output stage: double-buffers combiner samples (shadow -> active) and
// drives a fixed-period PWM pin. Overrun and underrun are kept as sticky debug flags.
module pwm_dac_out #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   input  logic             clr_flags,
   output logic             pwm_out,
   output logic             period_start,
   output logic             sample_taken,
   output logic [WIDTH-1:0] duty_active,
   output logic             overrun,
   output logic             underrun
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             shadow_full_q, shadow_full_d;
   logic             pwm_q, pwm_d;
   logic             pstart_q, pstart_d;
   logic             taken_q, taken_d;
   logic             ovr_q, ovr_d;
   logic             und_q, und_d;

   logic             boundary;
   logic             first_period;
   logic             load;
   logic             ovr_set;
   logic             und_set;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d      = state_q;
      cnt_d        = '0;
      boundary     = 1'b0;
      first_period = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d      = RUN;
               boundary     = 1'b1;
               first_period = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
            end else begin
               // Counter wraps P-1 -> 0 by natural WIDTH-bit overflow.
               cnt_d    = cnt_q + 1'b1;
               boundary = (cnt_q == '1);
            end
         end
         default: state_d = IDLE;
      endcase

      // The boundary transfer always consumes the old shadow, even if a new
      // sample lands in the shadow on the same edge.
      load    = boundary && shadow_full_q;
      duty_d  = load ? shadow_q : duty_q;
      und_set = boundary && !shadow_full_q && !first_period;
      ovr_set = (state_q == RUN) && sample_valid && shadow_full_q && !load;

      shadow_d      = sample_valid ? sample_in : shadow_q;
      shadow_full_d = sample_valid ? 1'b1 : (load ? 1'b0 : shadow_full_q);

      // Outputs are registered from next-state values so they line up with the
      // period cycle the counter is entering.
      pwm_d    = (state_d == RUN) && (cnt_d < duty_d);
      pstart_d = boundary;
      taken_d  = load;

      ovr_d = ovr_set | (ovr_q & ~clr_flags);
      und_d = und_set | (und_q & ~clr_flags);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!n_rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         duty_q        <= '0;
         pwm_q         <= 1'b0;
         pstart_q      <= 1'b0;
         taken_q       <= 1'b0;
         ovr_q         <= 1'b0;
         und_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         duty_q        <= duty_d;
         pwm_q         <= pwm_d;
         pstart_q      <= pstart_d;
         taken_q       <= taken_d;
         ovr_q         <= ovr_d;
         und_q         <= und_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = pstart_q;
   assign sample_taken = taken_q;
   assign duty_active  = duty_q;
   assign overrun      = ovr_q;
   assign underrun     = und_q;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Self-checking bench for pwm_dac_out at WIDTH=4 (P=16): per-period expectations
// are queued when stimulus is planned and checked cycle by cycle against the pin.
module tb_pwm_dac_out;

   localparam int W = 4;
   localparam int P = 16;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         en;
   logic [W-1:0] sample_in;
   logic         sample_valid;
   logic         clr_flags;
   logic         pwm_out;
   logic         period_start;
   logic         sample_taken;
   logic [W-1:0] duty_active;
   logic         overrun;
   logic         underrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] duty;
      logic         taken;
   } exp_t;

   exp_t sb[$];

   logic         stim_v[P];
   logic [W-1:0] stim_d[P];
   logic         stim_c[P];
   int           exp_ovr[P];
   int           exp_und[P];
   int           en_off_at;

   pwm_dac_out #(.WIDTH(W)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .en           (en),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .clr_flags    (clr_flags),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .sample_taken (sample_taken),
      .duty_active  (duty_active),
      .overrun      (overrun),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_stim();
      for (int i = 0; i < P; i++) begin
         stim_v[i]  = 1'b0;
         stim_d[i]  = '0;
         stim_c[i]  = 1'b0;
         exp_ovr[i] = -1;
         exp_und[i] = -1;
      end
      en_off_at = -1;
   endtask

   // Checks ncyc cycles of one PWM period starting at its cycle 0 against the
   // next queued expectation, driving the planned per-cycle stimulus.
   task automatic run_period(input string tag, input int ncyc);
      exp_t e;
      logic exp_ps;
      logic exp_pwm;
      logic exp_tk;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      for (int c = 0; c < ncyc; c++) begin
         exp_ps  = (c == 0);
         exp_pwm = (c < int'(e.duty));
         exp_tk  = (c == 0) && e.taken;
         checks++;
         if (period_start !== exp_ps) begin
            errors++;
            $display("FAIL %s c=%0d period_start got %b exp %b", tag, c, period_start, exp_ps);
         end
         checks++;
         if (pwm_out !== exp_pwm) begin
            errors++;
            $display("FAIL %s c=%0d pwm_out got %b exp %b", tag, c, pwm_out, exp_pwm);
         end
         checks++;
         if (duty_active !== e.duty) begin
            errors++;
            $display("FAIL %s c=%0d duty_active got %0d exp %0d", tag, c, duty_active, e.duty);
         end
         checks++;
         if (sample_taken !== exp_tk) begin
            errors++;
            $display("FAIL %s c=%0d sample_taken got %b exp %b", tag, c, sample_taken, exp_tk);
         end
         if (exp_ovr[c] >= 0) begin
            checks++;
            if (overrun !== 1'(exp_ovr[c])) begin
               errors++;
               $display("FAIL %s c=%0d overrun got %b exp %0d", tag, c, overrun, exp_ovr[c]);
            end
         end
         if (exp_und[c] >= 0) begin
            checks++;
            if (underrun !== 1'(exp_und[c])) begin
               errors++;
               $display("FAIL %s c=%0d underrun got %b exp %0d", tag, c, underrun, exp_und[c]);
            end
         end
         sample_valid = stim_v[c];
         sample_in    = stim_d[c];
         clr_flags    = stim_c[c];
         if (c == en_off_at) en = 1'b0;
         step();
      end
      sample_valid = 1'b0;
      clr_flags    = 1'b0;
      clear_stim();
   endtask

   task automatic test_reset();
      n_rst        = 1'b0;
      en           = 1'b0;
      clr_flags    = 1'b0;
      sample_valid = 1'b1;
      sample_in    = 4'd9;
      step();
      step();
      checks++;
      if ({pwm_out, period_start, sample_taken, overrun, underrun} !== 5'b0) begin
         errors++;
         $display("FAIL reset flags got %b exp 00000",
                  {pwm_out, period_start, sample_taken, overrun, underrun});
      end
      checks++;
      if (duty_active !== 4'd0) begin
         errors++;
         $display("FAIL reset duty_active got %0d exp 0", duty_active);
      end
      sample_valid = 1'b0;
      n_rst        = 1'b1;
      step();
      checks++;
      if ({pwm_out, period_start, duty_active} !== 6'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %b exp 0", {pwm_out, period_start, duty_active});
      end
   endtask

   task automatic test_no_sample();
      en = 1'b1;
      step();
      sb.push_back('{duty: 4'd0, taken: 1'b0});
      for (int i = 0; i < P; i++) exp_und[i] = 0;
      run_period("no_sample_p1", P);
      sb.push_back('{duty: 4'd0, taken: 1'b0});
      for (int i = 0; i < P; i++) exp_und[i] = 1;
      run_period("no_sample_p2", P);
   endtask

   task automatic test_idle_load();
      en        = 1'b0;
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      checks++;
      if ({pwm_out, period_start, underrun} !== 3'b000) begin
         errors++;
         $display("FAIL idle_entry got %b exp 000", {pwm_out, period_start, underrun});
      end
      sample_valid = 1'b1;
      sample_in    = 4'd2;
      step();
      sample_in = 4'd5;
      step();
      sample_valid = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL idle_overwrite overrun got %b exp 0", overrun);
      end
      en = 1'b1;
      step();
      sb.push_back('{duty: 4'd5, taken: 1'b1});
      for (int i = 0; i < P; i++) exp_und[i] = 0;
      run_period("idle_load_p1", P);
      sb.push_back('{duty: 4'd5, taken: 1'b0});
      for (int i = 0; i < P; i++) exp_und[i] = 1;
      run_period("idle_load_p2", P);
   endtask

   task automatic test_mid_period_update();
      sb.push_back('{duty: 4'd5, taken: 1'b0});
      sb.push_back('{duty: 4'd9, taken: 1'b1});
      stim_v[6] = 1'b1;
      stim_d[6] = 4'd9;
      for (int i = 0; i < P; i++) exp_ovr[i] = 0;
      run_period("update_p1", P);
      for (int i = 0; i < P; i++) exp_ovr[i] = 0;
      run_period("update_p2", P);
   endtask

   task automatic test_overrun();
      sb.push_back('{duty: 4'd9, taken: 1'b0});
      stim_v[2] = 1'b1; stim_d[2] = 4'd3;
      stim_v[5] = 1'b1; stim_d[5] = 4'd12;
      for (int i = 0; i < P; i++) exp_ovr[i] = (i >= 6) ? 1 : 0;
      run_period("overrun_set", P);
      sb.push_back('{duty: 4'd12, taken: 1'b1});
      stim_c[3] = 1'b1;
      stim_v[6] = 1'b1; stim_d[6] = 4'd1;
      stim_v[9] = 1'b1; stim_d[9] = 4'd2; stim_c[9] = 1'b1;
      for (int i = 0; i < P; i++) exp_ovr[i] = (i <= 3 || i >= 10) ? 1 : 0;
      run_period("overrun_clear", P);
   endtask

   task automatic test_boundary_collision();
      sb.push_back('{duty: 4'd2, taken: 1'b1});
      stim_c[0]  = 1'b1;
      stim_v[3]  = 1'b1; stim_d[3]  = 4'd4;
      stim_v[15] = 1'b1; stim_d[15] = 4'd7;
      for (int i = 0; i < P; i++) exp_ovr[i] = (i == 0) ? 1 : 0;
      run_period("collide_pre", P);
      sb.push_back('{duty: 4'd4, taken: 1'b1});
      for (int i = 0; i < P; i++) exp_ovr[i] = 0;
      run_period("collide_old", P);
      sb.push_back('{duty: 4'd7, taken: 1'b1});
      stim_v[4] = 1'b1; stim_d[4] = 4'd15;
      for (int i = 0; i < P; i++) exp_ovr[i] = 0;
      run_period("collide_new", P);
   endtask

   task automatic test_disable_and_reset();
      sb.push_back('{duty: 4'd15, taken: 1'b1});
      en_off_at = 8;
      run_period("disable_run", 9);
      checks++;
      if ({pwm_out, period_start, sample_taken} !== 3'b000) begin
         errors++;
         $display("FAIL disable_outputs got %b exp 000", {pwm_out, period_start, sample_taken});
      end
      checks++;
      if (duty_active !== 4'd15) begin
         errors++;
         $display("FAIL disable_duty_hold got %0d exp 15", duty_active);
      end
      en = 1'b1;
      step();
      sb.push_back('{duty: 4'd15, taken: 1'b0});
      for (int i = 0; i < P; i++) exp_und[i] = 0;
      run_period("reenable", P);
      sb.push_back('{duty: 4'd15, taken: 1'b0});
      stim_v[2] = 1'b1; stim_d[2] = 4'd6;
      exp_und[0] = 1;
      run_period("pre_reset", 5);
      n_rst = 1'b0;
      step();
      checks++;
      if ({pwm_out, period_start, sample_taken, overrun, underrun} !== 5'b0) begin
         errors++;
         $display("FAIL midrun_reset flags got %b exp 00000",
                  {pwm_out, period_start, sample_taken, overrun, underrun});
      end
      checks++;
      if (duty_active !== 4'd0) begin
         errors++;
         $display("FAIL midrun_reset duty got %0d exp 0", duty_active);
      end
      n_rst = 1'b1;
      step();
      sb.push_back('{duty: 4'd0, taken: 1'b0});
      for (int i = 0; i < P; i++) exp_und[i] = 0;
      run_period("post_reset", P);
   endtask

   initial begin
      clear_stim();
      test_reset();
      test_no_sample();
      test_idle_load();
      test_mid_period_update();
      test_overrun();
      test_boundary_collision();
      test_disable_and_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
